elevator_bank_controller: RTL and testbench
===========================================

// Module: elevator_bank_controller
// PURPOSE
//  Parametrised N-car, F-floor elevator bank for the simulation core. Per-car LOOK scheduling,
//  timed travel and door dwell. Cost-based dispatch of shared hall calls to the cheapest car.
//  Sits between request capture (car destinations, hall buttons) and the display/scoring logic.
//  Positions are reported in half-floor units.
// PARAMETERS
//  NUM_CARS      2   number of cars (1..8)
//  NUM_FLOORS    6   floors per shaft (2..16)
//  TRAVEL_CYCLES 4   enabled cycles per half-floor step (>=1)
//  DOOR_CYCLES   8   enabled cycles the door stays open (>=1)
//  POS_W = $clog2(2*NUM_FLOORS-1) (derived localparam)
// PORTS
//  clk            in   1                    system clock
//  rst            in   1                    asynchronous reset, active-low
//  simState       in   2                    START/SIM/PAUSE/ENDING; en = (simState==SIM)
//  car_dest       in   NUM_CARS*NUM_FLOORS  car-panel presses; bits [c*NUM_FLOORS +: NUM_FLOORS] belong to car c
//  hall_req       in   NUM_FLOORS           shared hall-call presses, level or pulse
//  half_pos       out  NUM_CARS*POS_W       per-car position, half floors; even value = at floor value/2
//  directions     out  NUM_CARS             1 = up, 0 = down; holds last value when idle
//  door_open      out  NUM_CARS             car c door open
//  hall_lit       out  NUM_FLOORS           hall call pending (latched, unserved)
// BEHAVIOUR
//  Reset (rst==0, async): half_pos=0, directions=all 1, door_open=0, hall_lit=0, all pending cleared,
//   car FSMs IDLE, counters 0.
//  Request capture (every state except START):
//   - any asserted car_dest/hall_req bit sets the matching pending bit on the next edge.
//   - START synchronously clears all pending/hall_lit; positions hold.
//  Gating:
//   - PAUSE and ENDING: FSMs and counters frozen; requests still latch.
//   - SIM: normal operation.
//  Dispatch (en only):
//   - each cycle, the lowest-numbered floor f with hall_lit[f] set and not yet assigned is assigned
//     to one car. At most one assignment per cycle.
//   - cost(c) = |half_pos[c] - 2f| + (moving away from f ? 2*NUM_FLOORS : 0).
//   - the car with minimum cost wins; ties go to the lowest index.
//   - assignment sets pend[c][f]. hall_lit[f] clears when any car opens its door at f.
//  Car FSM (per car, en-gated):
//   - IDLE:
//     - pend at current floor (even pos) -> DOOR.
//     - else any pend -> MOVE, dir toward nearest pend; dir keeps its prior value if equidistant.
//     - else stay IDLE.
//   - MOVE: counter counts to TRAVEL_CYCLES, then pos += dir ? 1 : -1 and counter clears.
//     - on reaching even pos with pend at that floor -> DOOR.
//     - otherwise at even pos, apply LOOK: keep dir while pend ahead; reverse if only behind;
//       if none, go IDLE.
//   - DOOR: door_open=1 starting the cycle after entry. pend[c][floor] and hall_lit[floor] clear on entry.
//     - a press for this floor while in DOOR clears and restarts the dwell counter.
//     - after DOOR_CYCLES enabled cycles -> IDLE, door_open=0.
//  Boundaries:
//   - pos saturates at 0 and 2*(NUM_FLOORS-1); dir is forced toward the interior at the ends.
//   - a car never moves with door_open=1.
//   - a request for the current floor while mid-half-step is served only at the next even pos
//     via LOOK (no reversal mid-step).
//   - simultaneous hall_req and car_dest for the same floor/car: single stop, both cleared.
//   - reset mid-MOVE returns the car to pos 0 immediately (no partial state retained).
// STRUCTURE
//  Package elevator_pkg:
//   - sim_state_t {START=0, SIM=1, PAUSE=2, ENDING=3}
//   - car_state_t {IDLE, MOVE, DOOR}
//   - function abs_diff
//  Sub-module elevator_car (one per car, generate loop): FSM, travel/dwell counters, LOOK direction logic.
//   - takes its pend vector; returns pos, dir, door, serve_floor strobe.
//  Top holds hall_lit, the dispatch cost comparator tree, and the pending-bit set/clear arbitration.
// TESTING
//  1. Reset, SIM, car_dest bit 2 (car0, floor 2) one cycle -> half_pos[0] steps 0->1->2->3->4,
//     one step per 4 cycles; door_open[0] high exactly 8 cycles; directions[0]=1 throughout.
//  2. Car0 at floor 0, car1 at floor 5, hall_req[4] -> assigned to car1 (cost 2 vs 8);
//     car0 stays IDLE; hall_lit[4] clears when door_open[1] rises at half_pos 8.
//  3. Car0 moving up from 0 with pend floor 4; car_dest floor 1 mid-travel, then floor 0
//     -> stops at 1 then 4, then reverses to 0 (LOOK order).
//  4. PAUSE for 10 cycles mid-step -> half_pos and counters frozen; requests latched;
//     on SIM the step completes after the remaining cycles.
//  5. Equal cost hall_req[2] with both cars IDLE at floor 2 -> car0 opens its door; car1 stays IDLE.
//  6. Assert rst low mid-DOOR, then release -> all outputs at reset values;
//     START clears hall_lit set during the reset release.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator bank.
//   sim_state_t : global simulation phase driven by the sequencer
//   car_state_t : per-car controller state
//   abs_diff    : unsigned distance used by the dispatch cost
package elevator_pkg;

  typedef enum logic [1:0] {
    START  = 2'd0,
    SIM    = 2'd1,
    PAUSE  = 2'd2,
    ENDING = 2'd3
  } sim_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } car_state_t;

  // Wide enough for |pos - 2f| + 2*NUM_FLOORS with NUM_FLOORS <= 16.
  localparam int unsigned CostW = 8;

  function automatic logic [CostW-1:0] abs_diff(input logic [CostW-1:0] a,
                                                input logic [CostW-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/elevator_car.sv
// Single elevator car: IDLE/MOVE/DOOR controller with timed half-floor travel, door dwell and
// LOOK direction selection.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   en_i           : advance FSM and counters this cycle
//   pend_i         : pending stops for this car, one bit per floor
//   press_i        : raw presses that concern this car (own panel | hall buttons)
//   pos_o          : position in half floors
//   dir_o          : 1 = up, 0 = down
//   door_o         : door open
//   moving_o       : car is in MOVE
//   serve_floor_o  : one-hot strobe, floor being served on this edge (DOOR entry)
//   door_at_o      : one-hot floor where the door is currently open
module elevator_car
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS    = 6,
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 8,
  localparam int unsigned POS_W        = $clog2(2 * NUM_FLOORS - 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [NUM_FLOORS-1:0] pend_i,
  input  logic [NUM_FLOORS-1:0] press_i,
  output logic [POS_W-1:0]      pos_o,
  output logic                  dir_o,
  output logic                  door_o,
  output logic                  moving_o,
  output logic [NUM_FLOORS-1:0] serve_floor_o,
  output logic [NUM_FLOORS-1:0] door_at_o
);

  localparam int unsigned CntMax = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [POS_W-1:0] PosTop = POS_W'(2 * (NUM_FLOORS - 1));

  car_state_t      state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [POS_W-1:0]      pos_step, eval_pos, fpos, dist_up, dist_dn;
  logic [NUM_FLOORS-1:0] here_oh;
  logic                  pend_above, pend_below, pend_here, press_here;

  always_comb begin
    state_d       = state_q;
    pos_d         = pos_q;
    dir_d         = dir_q;
    cnt_d         = cnt_q;
    serve_floor_o = '0;
    pos_step      = dir_q ? (pos_q + 1'b1) : (pos_q - 1'b1);
    // In MOVE, decisions are taken against the position being stepped into.
    eval_pos      = (state_q == MOVE) ? pos_step : pos_q;
    fpos          = '0;
    here_oh       = '0;
    pend_above    = 1'b0;
    pend_below    = 1'b0;
    dist_up       = '1;
    dist_dn       = '1;

    for (int f = 0; f < NUM_FLOORS; f++) begin
      fpos = POS_W'(2 * f);
      here_oh[f] = (fpos == eval_pos);
      if (pend_i[f] && (fpos > eval_pos)) begin
        pend_above = 1'b1;
        if ((fpos - eval_pos) < dist_up) dist_up = fpos - eval_pos;
      end
      if (pend_i[f] && (fpos < eval_pos)) begin
        pend_below = 1'b1;
        if ((eval_pos - fpos) < dist_dn) dist_dn = eval_pos - fpos;
      end
    end
    pend_here  = |(pend_i & here_oh);
    press_here = |(press_i & here_oh);

    if (en_i) begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (pend_here) begin
            state_d       = DOOR;
            serve_floor_o = here_oh;
          end else if (pend_above || pend_below) begin
            state_d = MOVE;
            // Equidistant targets leave dir unchanged.
            if (pend_above && (!pend_below || (dist_up < dist_dn))) begin
              dir_d = 1'b1;
            end else if (pend_below && (!pend_above || (dist_dn < dist_up))) begin
              dir_d = 1'b0;
            end
          end
        end
        MOVE: begin
          if (cnt_q == CntW'(TRAVEL_CYCLES - 1)) begin
            cnt_d = '0;
            pos_d = pos_step;
            if (!pos_step[0]) begin
              if (pend_here) begin
                state_d       = DOOR;
                serve_floor_o = here_oh;
              end else if (dir_q ? pend_above : pend_below) begin
                dir_d = dir_q;
              end else if (dir_q ? pend_below : pend_above) begin
                dir_d = ~dir_q;
              end else begin
                state_d = IDLE;
              end
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DOOR: begin
          if (press_here) begin
            cnt_d = '0;
          end else if (cnt_q == CntW'(DOOR_CYCLES - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // At the shaft ends the only way out is toward the interior.
    if (pos_d == '0) begin
      dir_d = 1'b1;
    end else if (pos_d == PosTop) begin
      dir_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pos_q   <= '0;
      dir_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pos_o     = pos_q;
  assign dir_o     = dir_q;
  assign door_o    = (state_q == DOOR);
  assign moving_o  = (state_q == MOVE);
  assign door_at_o = (state_q == DOOR) ? here_oh : '0;

endmodule

// File: rtl/elevator_bank_controller.sv
// N-car elevator bank: request capture, hall-call latching and cost-based hall dispatch around a
// set of elevator_car instances.
//   clk, rst    : clock, asynchronous active-low reset
//   simState    : START/SIM/PAUSE/ENDING, cars advance only in SIM
//   car_dest    : car-panel presses, NUM_FLOORS bits per car
//   hall_req    : shared hall-call presses
//   half_pos    : per-car position in half floors, POS_W bits per car
//   directions  : per-car direction, 1 = up
//   door_open   : per-car door open
//   hall_lit    : latched, unserved hall calls
module elevator_bank_controller
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_CARS      = 2,
  parameter int unsigned NUM_FLOORS    = 6,
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 8,
  localparam int unsigned POS_W        = $clog2(2 * NUM_FLOORS - 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     simState,
  input  logic [NUM_CARS*NUM_FLOORS-1:0] car_dest,
  input  logic [NUM_FLOORS-1:0]          hall_req,
  output logic [NUM_CARS*POS_W-1:0]      half_pos,
  output logic [NUM_CARS-1:0]            directions,
  output logic [NUM_CARS-1:0]            door_open,
  output logic [NUM_FLOORS-1:0]          hall_lit
);

  localparam int unsigned CarW = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;

  sim_state_t sim;
  logic       en, start;

  assign sim   = sim_state_t'(simState);
  assign en    = (sim == SIM);
  assign start = (sim == START);

  logic [NUM_FLOORS-1:0] pend_q [NUM_CARS];
  logic [NUM_FLOORS-1:0] pend_d [NUM_CARS];
  logic [NUM_FLOORS-1:0] serve  [NUM_CARS];
  logic [NUM_FLOORS-1:0] door_at[NUM_CARS];
  logic [POS_W-1:0]      pos    [NUM_CARS];
  logic [NUM_CARS-1:0]   moving;

  logic [NUM_FLOORS-1:0] hall_lit_q, hall_lit_d;
  logic [NUM_FLOORS-1:0] asg_q, asg_d;  // hall calls already handed to a car

  for (genvar c = 0; c < NUM_CARS; c++) begin : g_car
    elevator_car #(
      .NUM_FLOORS   (NUM_FLOORS),
      .TRAVEL_CYCLES(TRAVEL_CYCLES),
      .DOOR_CYCLES  (DOOR_CYCLES)
    ) u_car (
      .clk_i        (clk),
      .rst_ni       (rst),
      .en_i         (en),
      .pend_i       (pend_q[c]),
      .press_i      (car_dest[c*NUM_FLOORS +: NUM_FLOORS] | hall_req),
      .pos_o        (pos[c]),
      .dir_o        (directions[c]),
      .door_o       (door_open[c]),
      .moving_o     (moving[c]),
      .serve_floor_o(serve[c]),
      .door_at_o    (door_at[c])
    );
    assign half_pos[c*POS_W +: POS_W] = pos[c];
  end

  logic [NUM_FLOORS-1:0] serve_any, absorb, cand, asg_floor, asg_oh;
  logic                  found, away;
  logic [CostW-1:0]      tgt_pos, pos_ext, cost, best_cost;
  logic [CarW-1:0]       best_car;

  always_comb begin
    serve_any = '0;
    absorb    = '0;
    for (int c = 0; c < NUM_CARS; c++) begin
      serve_any = serve_any | serve[c];
      absorb    = absorb | door_at[c];
    end

    // Floors being served this edge are not offered to another car.
    cand      = hall_lit_q & ~asg_q & ~serve_any;
    asg_floor = '0;
    found     = 1'b0;
    tgt_pos   = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (en && cand[f] && !found) begin
        found        = 1'b1;
        asg_floor[f] = 1'b1;
        tgt_pos      = CostW'(2 * f);
      end
    end

    // Strict '<' keeps the lowest index on equal cost.
    best_cost = '1;
    best_car  = '0;
    pos_ext   = '0;
    cost      = '0;
    away      = 1'b0;
    for (int c = 0; c < NUM_CARS; c++) begin
      pos_ext = CostW'(pos[c]);
      away    = moving[c] && ((directions[c] && (pos_ext > tgt_pos)) ||
                              (!directions[c] && (pos_ext < tgt_pos)));
      cost    = abs_diff(pos_ext, tgt_pos) + (away ? CostW'(2 * NUM_FLOORS) : '0);
      if (cost < best_cost) begin
        best_cost = cost;
        best_car  = CarW'(c);
      end
    end

    // Serve clears win over same-cycle sets; presses at an open door are absorbed.
    asg_oh = '0;
    for (int c = 0; c < NUM_CARS; c++) begin
      asg_oh    = (found && (best_car == CarW'(c))) ? asg_floor : '0;
      pend_d[c] = start ? '0 :
                  (pend_q[c] | (car_dest[c*NUM_FLOORS +: NUM_FLOORS] & ~door_at[c]) | asg_oh) &
                  ~serve[c];
    end
    hall_lit_d = start ? '0 : (hall_lit_q | (hall_req & ~absorb)) & ~serve_any;
    asg_d      = (asg_q | asg_floor) & hall_lit_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CARS; c++) pend_q[c] <= '0;
      hall_lit_q <= '0;
      asg_q      <= '0;
    end else begin
      for (int c = 0; c < NUM_CARS; c++) pend_q[c] <= pend_d[c];
      hall_lit_q <= hall_lit_d;
      asg_q      <= asg_d;
    end
  end

  assign hall_lit = hall_lit_q;

endmodule

// File: tb/tb_elevator_bank_controller.sv
// Directed self-checking bench for elevator_bank_controller (2 cars, 6 floors, 4/8 cycles).
module tb_elevator_bank_controller;

  localparam int POS_W = 4;
  localparam logic [1:0] StStart = 2'd0;
  localparam logic [1:0] StSim   = 2'd1;
  localparam logic [1:0] StPause = 2'd2;

  logic        clk;
  logic        rst;
  logic [1:0]  simState;
  logic [11:0] car_dest;
  logic [5:0]  hall_req;
  logic [7:0]  half_pos;
  logic [1:0]  directions;
  logic [1:0]  door_open;
  logic [5:0]  hall_lit;

  int checks   = 0;
  int failures = 0;

  int rec_en = 0;
  int n_stops = 0;
  int stops[4];
  logic prev_door0 = 1'b0;

  elevator_bank_controller #(
    .NUM_CARS     (2),
    .NUM_FLOORS   (6),
    .TRAVEL_CYCLES(4),
    .DOOR_CYCLES  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .simState  (simState),
    .car_dest  (car_dest),
    .hall_req  (hall_req),
    .half_pos  (half_pos),
    .directions(directions),
    .door_open (door_open),
    .hall_lit  (hall_lit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int pos_of(input int c);
    return int'(half_pos[c*POS_W +: POS_W]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later; logs car0 door-open positions.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rec_en != 0 && door_open[0] && !prev_door0 && n_stops < 4) begin
      stops[n_stops] = pos_of(0);
      n_stops++;
    end
    prev_door0 = door_open[0];
  endtask

  task automatic wait_pos(input int c, input int v, input int budget);
    int n = 0;
    while (pos_of(c) != v && n < budget) begin
      tick();
      n++;
    end
    chk($sformatf("wait_pos car%0d=%0d", c, v), pos_of(c), v);
  endtask

  // Wait until both cars sit at the given positions, doors shut, no hall calls, for 12 cycles.
  task automatic settle(input int p0, input int p1, input int budget);
    int n = 0;
    int stable = 0;
    while (stable < 12 && n < budget) begin
      tick();
      n++;
      if (pos_of(0) == p0 && pos_of(1) == p1 && door_open == 2'b00 && hall_lit == 6'b0) stable++;
      else stable = 0;
    end
    chk($sformatf("settle %0d/%0d", p0, p1), stable, 12);
  endtask

  initial begin
    int exp_pos;
    int exp_door;
    int early;
    int n;

    rst      = 1'b0;
    simState = StStart;
    car_dest = '0;
    hall_req = '0;
    #12;
    chk("reset half_pos", half_pos, 0);
    chk("reset directions", directions, 2'b11);
    chk("reset door_open", door_open, 0);
    chk("reset hall_lit", hall_lit, 0);
    rst = 1'b1;
    tick();

    // 1: car0 to floor 2, exact step and dwell timing.
    simState = StSim;
    car_dest = 12'b0000_0000_0100;
    for (int k = 1; k <= 27; k++) begin
      tick();
      if (k == 1) car_dest = '0;
      exp_pos  = (k < 6) ? 0 : ((k < 18) ? (k - 2) / 4 : 4);
      exp_door = (k >= 18 && k <= 25) ? 1 : 0;
      chk($sformatf("t1 pos0 k=%0d", k), pos_of(0), exp_pos);
      chk($sformatf("t1 door0 k=%0d", k), door_open[0], exp_door);
      chk($sformatf("t1 dir0 k=%0d", k), directions[0], 1);
    end
    chk("t1 pos1", pos_of(1), 0);

    // 2: car0 -> floor 0, car1 -> floor 5, then hall call at floor 4 goes to car1.
    car_dest = 12'b1000_0000_0001;
    tick();
    car_dest = '0;
    settle(0, 10, 200);
    chk("t2 directions at ends", directions, 2'b01);
    hall_req = 6'b010000;
    tick();
    hall_req = '0;
    chk("t2 hall_lit latched", hall_lit, 6'b010000);
    early = 0;
    n = 0;
    while (!door_open[1] && n < 40) begin
      tick();
      n++;
      if (!door_open[1] && !hall_lit[4]) early++;
    end
    chk("t2 door1 opened", door_open[1], 1);
    chk("t2 pos1 at door", pos_of(1), 8);
    chk("t2 hall_lit cleared", hall_lit, 0);
    chk("t2 hall_lit early clear", early, 0);
    chk("t2 car0 idle", {door_open[0], half_pos[3:0]}, 0);
    settle(0, 8, 100);

    // 3: LOOK order 1, 4, then reverse to 0.
    rec_en = 1;
    n_stops = 0;
    prev_door0 = door_open[0];
    car_dest = 12'b0000_0001_0000;
    tick();
    car_dest = '0;
    wait_pos(0, 1, 50);
    car_dest = 12'b0000_0000_0010;
    tick();
    car_dest = '0;
    wait_pos(0, 3, 100);
    car_dest = 12'b0000_0000_0001;
    tick();
    car_dest = '0;
    n = 0;
    while (n_stops < 3 && n < 200) begin
      tick();
      n++;
    end
    rec_en = 0;
    chk("t3 stop count", n_stops, 3);
    chk("t3 stop 1", stops[0], 2);
    chk("t3 stop 2", stops[1], 8);
    chk("t3 stop 3", stops[2], 0);
    settle(0, 8, 100);
    chk("t3 dir0 at bottom", directions[0], 1);

    // 4: PAUSE mid-step freezes travel while requests still latch.
    car_dest = 12'b0000_0000_0010;
    tick();
    car_dest = '0;
    tick();
    tick();
    tick();
    simState = StPause;
    hall_req = 6'b010000;
    for (int i = 0; i < 10; i++) begin
      tick();
      hall_req = '0;
    end
    chk("t4 pos0 frozen", pos_of(0), 0);
    chk("t4 hall_lit latched in pause", hall_lit, 6'b010000);
    chk("t4 no door in pause", door_open, 0);
    simState = StSim;
    tick();
    chk("t4 pos0 one before step", pos_of(0), 0);
    tick();
    chk("t4 pos0 step done", pos_of(0), 1);
    settle(2, 8, 150);

    // 5: equal cost hall call at floor 2 goes to car0.
    car_dest = 12'b0001_0000_0100;
    tick();
    car_dest = '0;
    settle(4, 4, 150);
    hall_req = 6'b000100;
    tick();
    hall_req = '0;
    chk("t5 hall_lit", hall_lit, 6'b000100);
    chk("t5 doors shut e1", door_open, 0);
    tick();
    chk("t5 doors shut e2", door_open, 0);
    tick();
    chk("t5 car0 door", door_open, 2'b01);
    chk("t5 hall_lit cleared", hall_lit, 0);
    tick();
    tick();
    tick();
    chk("t5 car1 stays", {door_open, half_pos[7:4]}, {2'b01, 4'd4});

    // 6: async reset mid-DOOR, then START clears a call latched right after release.
    #2;
    rst = 1'b0;
    #1;
    chk("t6 reset half_pos", half_pos, 0);
    chk("t6 reset directions", directions, 2'b11);
    chk("t6 reset door_open", door_open, 0);
    chk("t6 reset hall_lit", hall_lit, 0);
    simState = StSim;
    hall_req = 6'b001000;
    tick();
    chk("t6 hall_lit held in reset", hall_lit, 0);
    rst = 1'b1;
    tick();
    chk("t6 hall_lit after release", hall_lit, 6'b001000);
    hall_req = '0;
    simState = StStart;
    tick();
    chk("t6 START clears hall_lit", hall_lit, 0);
    tick();
    tick();
    chk("t6 positions held", half_pos, 0);
    chk("t6 doors shut", door_open, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
